// File: rtl/i2s_apb_sequencer.sv
// APB master that sequences an I2S transceiver: configure, preload TX, run, halt.
// Ports: pclk/preset, start/stop_req/cfg_word, tx_* producer, rx_* consumer,
//        tx_full/rx_empty flags, APB master (psel..pready), busy/done, counters.
module i2s_apb_sequencer #(
    parameter logic [31:0] ADR_OFFSET = 32'h0,
    parameter int unsigned PRELOAD    = 4,
    parameter int unsigned STOP_BIT   = 1
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        start,
    input  logic        stop_req,
    input  logic [31:0] cfg_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [31:0] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] rx_data,
    input  logic        tx_full,
    input  logic        rx_empty,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        busy,
    output logic        done,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    localparam logic [31:0] ADDR_CTRL    = ADR_OFFSET;
    localparam logic [31:0] ADDR_TXD     = ADR_OFFSET + 32'h4;
    localparam logic [31:0] ADDR_RXD     = ADR_OFFSET + 32'h8;
    localparam logic [31:0] STOP_MASK    = 32'h1 << STOP_BIT;
    localparam logic [15:0] PRELOAD_LAST = 16'(PRELOAD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_PRELOAD,
        ST_GO,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        ISS_NONE,
        ISS_CTRL,
        ISS_TXD,
        ISS_RXD
    } issue_t;

    state_t      state;
    state_t      state_next;
    issue_t      issue;
    logic [31:0] ctrl_data;
    logic [31:0] cfg_q;
    logic        stop_q;
    logic        last_rx;

    logic xfer_done;
    logic stop_now;
    logic tx_elig;
    logic rx_elig;
    logic grant_rx;

    assign xfer_done = psel & penable & pready;
    // A stop arriving in the completing cycle counts as already latched.
    assign stop_now  = stop_q | stop_req;
    assign tx_elig   = tx_valid & ~tx_full;
    // Only one RX word is buffered; no read while it is still pending.
    assign rx_elig   = ~rx_empty & ~rx_valid;
    // Round-robin: RX wins a tie unless it had the previous grant.
    assign grant_rx  = rx_elig & (~tx_elig | ~last_rx);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // New transfers are issued only while the bus is idle; completions
    // decide where the sequence goes next.
    always_comb begin
        state_next = state;
        issue      = ISS_NONE;
        ctrl_data  = cfg_q | STOP_MASK;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CFG;
                end
            end
            ST_CFG: begin
                if (psel) begin
                    if (xfer_done) begin
                        state_next = stop_now ? ST_HALT : ST_PRELOAD;
                    end
                end else if (stop_now) begin
                    state_next = ST_HALT;
                end else begin
                    issue = ISS_CTRL;
                end
            end
            ST_PRELOAD: begin
                if (psel) begin
                    if (xfer_done) begin
                        if (stop_now) begin
                            state_next = ST_HALT;
                        end else if (tx_count == PRELOAD_LAST) begin
                            state_next = ST_GO;
                        end
                    end
                end else if (stop_now) begin
                    state_next = ST_HALT;
                end else if (tx_elig) begin
                    issue = ISS_TXD;
                end
            end
            ST_GO: begin
                ctrl_data = cfg_q & ~STOP_MASK;
                if (psel) begin
                    if (xfer_done) begin
                        state_next = stop_now ? ST_HALT : ST_RUN;
                    end
                end else if (stop_now) begin
                    state_next = ST_HALT;
                end else begin
                    issue = ISS_CTRL;
                end
            end
            ST_RUN: begin
                if (psel) begin
                    if (xfer_done && stop_now) begin
                        state_next = ST_HALT;
                    end
                end else if (stop_now) begin
                    state_next = ST_HALT;
                end else if (grant_rx) begin
                    issue = ISS_RXD;
                end else if (tx_elig) begin
                    issue = ISS_TXD;
                end
            end
            ST_HALT: begin
                if (psel) begin
                    if (xfer_done) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    issue = ISS_CTRL;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_count <= '0;
            rx_count <= '0;
            cfg_q    <= '0;
            stop_q   <= 1'b0;
            last_rx  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == ST_IDLE && start) begin
                cfg_q    <= cfg_word;
                tx_count <= '0;
                rx_count <= '0;
                busy     <= 1'b1;
            end

            if (state == ST_HALT && state_next == ST_IDLE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end

            if (state == ST_IDLE) begin
                stop_q <= start & stop_req;
            end else if (state_next == ST_IDLE) begin
                stop_q <= 1'b0;
            end else if (stop_req) begin
                stop_q <= 1'b1;
            end

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // Setup cycle -> access cycle; the TX word was taken at issue.
            if (psel && !penable) begin
                penable  <= 1'b1;
                tx_ready <= 1'b0;
            end

            if (xfer_done) begin
                psel    <= 1'b0;
                penable <= 1'b0;
                if (!pwrite) begin
                    rx_data  <= prdata;
                    rx_valid <= 1'b1;
                    if (rx_count != 16'hFFFF) begin
                        rx_count <= rx_count + 16'd1;
                    end
                end else if (paddr == ADDR_TXD && tx_count != 16'hFFFF) begin
                    tx_count <= tx_count + 16'd1;
                end
            end

            unique case (issue)
                ISS_CTRL: begin
                    psel   <= 1'b1;
                    pwrite <= 1'b1;
                    paddr  <= ADDR_CTRL;
                    pwdata <= ctrl_data;
                end
                ISS_TXD: begin
                    psel     <= 1'b1;
                    pwrite   <= 1'b1;
                    paddr    <= ADDR_TXD;
                    pwdata   <= tx_data;
                    tx_ready <= 1'b1;
                end
                ISS_RXD: begin
                    psel   <= 1'b1;
                    pwrite <= 1'b0;
                    paddr  <= ADDR_RXD;
                end
                ISS_NONE: begin
                end
            endcase

            if (issue == ISS_RXD) begin
                last_rx <= 1'b1;
            end else if (issue == ISS_TXD && state == ST_RUN) begin
                last_rx <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// Directed bench for i2s_apb_sequencer: APB slave model with wait states,
// TX producer, transfer log, and hand-computed expectations per session.
module tb_i2s_apb_sequencer;

    localparam logic [31:0] TX_BASE = 32'h1000_0000;
    localparam logic [31:0] RX_BASE = 32'hA000_0000;

    logic        pclk = 1'b0;
    logic        preset;
    logic        start;
    logic        stop_req;
    logic [31:0] cfg_word;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data = TX_BASE;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        tx_full;
    logic        rx_empty;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = RX_BASE;
    logic        pready = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    i2s_apb_sequencer #(
        .ADR_OFFSET(32'h0),
        .PRELOAD   (4),
        .STOP_BIT  (1)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .start   (start),
        .stop_req(stop_req),
        .cfg_word(cfg_word),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data (rx_data),
        .tx_full (tx_full),
        .rx_empty(rx_empty),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .busy    (busy),
        .done    (done),
        .tx_count(tx_count),
        .rx_count(rx_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        int          len;
        bit          unst;
        int          idx;
    } xfer_t;

    xfer_t       xlog[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          wait_states = 0;
    int          acc = 0;
    int          n_txd = 0;
    int          n_rxd = 0;
    bit          tx_pend = 1'b0;
    int          cur_len = 0;
    logic [31:0] a0 = '0;
    logic [31:0] d0 = '0;
    bit          unst = 1'b0;

    // Environment on the falling edge: producer, APB slave, monitor.
    always @(negedge pclk) begin
        xfer_t e;
        if (tx_pend) tx_data = tx_data + 32'h1;
        tx_pend = tx_valid && tx_ready;
        if (psel && penable) begin
            pready = (acc >= wait_states);
            acc++;
        end else begin
            acc = 0;
            pready = 1'b0;
        end
        prdata = RX_BASE + 32'(n_rxd);
        if (psel) begin
            if (!penable) begin
                cur_len = 1;
                a0 = paddr;
                d0 = pwdata;
                unst = 1'b0;
            end else begin
                cur_len++;
                if (paddr !== a0 || pwdata !== d0) unst = 1'b1;
            end
            if (penable && pready) begin
                e.addr = paddr;
                e.write = pwrite;
                e.data = pwrite ? pwdata : prdata;
                e.len = cur_len;
                e.unst = unst;
                e.idx = 0;
                if (pwrite && paddr == 32'h4) begin
                    e.idx = n_txd;
                    n_txd++;
                end
                if (!pwrite) begin
                    e.idx = n_rxd;
                    n_rxd++;
                end
                xlog.push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [31:0] cfg, input bit with_stop);
        cfg_word = cfg;
        start = 1'b1;
        stop_req = with_stop;
        tick();
        start = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (xlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (xlog.size() < n) chk("log_timeout", 32'(xlog.size()), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", {31'b0, done}, 32'h1);
        chk("busy_clr", {31'b0, busy}, 32'h0);
        tick();
        chk("done_pulse", {31'b0, done}, 32'h0);
    endtask

    function automatic int count_at(input int from, input logic [31:0] a);
        int c = 0;
        for (int i = from; i < xlog.size(); i++) begin
            if (xlog[i].addr == a) c++;
        end
        return c;
    endfunction

    task automatic chk_xfer(input string tag, input int i,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int len);
        chk({tag, "_addr"}, xlog[i].addr, addr);
        chk({tag, "_data"}, xlog[i].data, data);
        chk({tag, "_len"}, 32'(xlog[i].len), 32'(len));
        chk({tag, "_stable"}, {31'b0, xlog[i].unst}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        preset = 1'b1;
        start = 1'b0;
        stop_req = 1'b0;
        cfg_word = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        tx_full = 1'b0;
        rx_empty = 1'b1;
        tick(3);

        chk("rst_psel", {31'b0, psel}, 32'h0);
        chk("rst_penable", {31'b0, penable}, 32'h0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'h0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'h0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_tx_count", {16'b0, tx_count}, 32'h0);
        chk("rst_rx_count", {16'b0, rx_count}, 32'h0);
        preset = 1'b0;
        tick();

        // stop in IDLE does nothing
        pulse_stop();
        tick(2);
        chk("idle_stop_busy", {31'b0, busy}, 32'h0);
        chk("idle_stop_psel", {31'b0, psel}, 32'h0);

        // basic session, zero wait states
        base = xlog.size();
        wait_states = 0;
        tx_valid = 1'b1;
        pulse_start(32'h0000_00F0, 1'b0);
        chk("s1_busy", {31'b0, busy}, 32'h1);
        wait_log(base + 6, 200);
        chk_xfer("s1_cfg", base, 32'h0, 32'h0000_00F2, 2);
        for (int i = 1; i <= 4; i++) begin
            chk_xfer("s1_pre", base + i, 32'h4, TX_BASE + 32'(i - 1), 2);
        end
        chk_xfer("s1_go", base + 5, 32'h0, 32'h0000_00F0, 2);
        pulse_stop();
        wait_done(200);
        chk("s1_halt_addr", xlog[xlog.size() - 1].addr, 32'h0);
        chk("s1_halt_data", xlog[xlog.size() - 1].data, 32'h0000_00F2);
        chk("s1_tx_count", {16'b0, tx_count}, 32'(count_at(base, 32'h4)));
        tick(3);
        chk("s1_tx_hold", {16'b0, tx_count}, 32'(count_at(base, 32'h4)));

        // wait states; start while busy is ignored
        base = xlog.size();
        wait_states = 3;
        pulse_start(32'h1234_5601, 1'b0);
        wait_log(base + 2, 200);
        chk_xfer("ws_cfg", base, 32'h0, 32'h1234_5603, 5);
        chk_xfer("ws_txd", base + 1, 32'h4,
                 TX_BASE + 32'(xlog[base + 1].idx), 5);
        pulse_start(32'hDEAD_0000, 1'b0);
        pulse_stop();
        wait_done(400);
        chk("ws_halt_data", xlog[xlog.size() - 1].data, 32'h1234_5603);
        chk("ws_tx_count", {16'b0, tx_count}, 32'(count_at(base, 32'h4)));

        // round-robin arbitration
        base = xlog.size();
        wait_states = 0;
        rx_empty = 1'b0;
        rx_ready = 1'b1;
        pulse_start(32'h0, 1'b0);
        wait_log(base + 14, 400);
        pulse_stop();
        wait_done(200);
        for (int i = 6; i < 14; i++) begin
            chk("rr_kind", xlog[base + i].addr, (i % 2 == 0) ? 32'h8 : 32'h4);
        end
        chk("rr_tx_count", {16'b0, tx_count}, 32'(count_at(base, 32'h4)));
        chk("rr_rx_count", {16'b0, rx_count}, 32'(count_at(base, 32'h8)));
        chk("rr_rx_data", rx_data, RX_BASE + 32'(n_rxd - 1));

        // TX FIFO full in RUN, RX back-pressure
        base = xlog.size();
        rx_empty = 1'b1;
        rx_ready = 1'b0;
        pulse_start(32'h0000_0A00, 1'b0);
        wait_log(base + 5, 200);
        tx_full = 1'b1;
        rx_empty = 1'b0;
        tick(30);
        chk("full_cfg", xlog[base].data, 32'h0000_0A02);
        chk("full_go", xlog[base + 5].data, 32'h0000_0A00);
        chk("full_ntx", 32'(count_at(base, 32'h4)), 32'd4);
        chk("full_nrx", 32'(count_at(base, 32'h8)), 32'd1);
        chk("full_rx_valid", {31'b0, rx_valid}, 32'h1);
        chk("full_rx_data", rx_data, RX_BASE + 32'(n_rxd - 1));
        rx_ready = 1'b1;
        tick(30);
        chk("full_more_rx", {31'b0, count_at(base, 32'h8) > 3}, 32'h1);
        chk("full_ntx2", 32'(count_at(base, 32'h4)), 32'd4);
        rx_ready = 1'b0;
        tick(10);
        pulse_stop();
        wait_done(200);
        chk("full_rx_count", {16'b0, rx_count}, 32'(count_at(base, 32'h8)));
        chk("full_tx_count", {16'b0, tx_count}, 32'd4);
        tick(5);
        chk("hold_rx_valid", {31'b0, rx_valid}, 32'h1);
        chk("hold_rx_data", rx_data, RX_BASE + 32'(n_rxd - 1));
        rx_ready = 1'b1;
        tick(2);
        chk("hold_rx_clr", {31'b0, rx_valid}, 32'h0);

        // stop during the second preload write
        base = xlog.size();
        tx_full = 1'b0;
        rx_empty = 1'b1;
        pulse_start(32'h0000_0055, 1'b0);
        k = 0;
        while (!(psel && paddr == 32'h4 && xlog.size() == base + 2) && k < 100) begin
            tick();
            k++;
        end
        chk("pre2_seen", {31'b0, psel}, 32'h1);
        pulse_stop();
        wait_done(100);
        chk("pre2_nlog", 32'(xlog.size() - base), 32'd4);
        chk("pre2_txd", xlog[base + 2].addr, 32'h4);
        chk_xfer("pre2_halt", base + 3, 32'h0, 32'h0000_0057, 2);
        chk("pre2_tx_count", {16'b0, tx_count}, 32'd2);

        // reset in the middle of an access
        base = xlog.size();
        wait_states = 3;
        pulse_start(32'h0000_0100, 1'b0);
        k = 0;
        while (!(psel && penable) && k < 20) begin
            tick();
            k++;
        end
        chk("mid_penable", {31'b0, penable}, 32'h1);
        preset = 1'b1;
        tick();
        chk("mid_psel", {31'b0, psel}, 32'h0);
        chk("mid_penable0", {31'b0, penable}, 32'h0);
        chk("mid_busy", {31'b0, busy}, 32'h0);
        chk("mid_tx_count", {16'b0, tx_count}, 32'h0);
        chk("mid_rx_count", {16'b0, rx_count}, 32'h0);
        chk("mid_nolog", 32'(xlog.size()), 32'(base));
        preset = 1'b0;
        tick();

        // full session after reset
        base = xlog.size();
        wait_states = 0;
        pulse_start(32'h0000_0100, 1'b0);
        wait_log(base + 6, 200);
        chk_xfer("post_cfg", base, 32'h0, 32'h0000_0102, 2);
        for (int i = 1; i <= 4; i++) begin
            chk("post_pre", xlog[base + i].addr, 32'h4);
        end
        chk_xfer("post_go", base + 5, 32'h0, 32'h0000_0100, 2);
        pulse_stop();
        wait_done(200);
        chk("post_tx_count", {16'b0, tx_count}, 32'(count_at(base, 32'h4)));

        // start and stop together
        base = xlog.size();
        pulse_start(32'h0000_0300, 1'b1);
        wait_done(100);
        chk("both_halt", xlog[xlog.size() - 1].data, 32'h0000_0302);
        chk("both_tx_count", {16'b0, tx_count}, 32'h0);
        chk("both_nogo", 32'(count_at(base, 32'h4)), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_apb_sequencer.md
I2S_APB_SEQUENCER -- requirements
Module: i2s_apb_sequencer

Interface
REQ-001 Parameter ADR_OFFSET, default 32'h0: base address of the target transceiver register block.
REQ-002 Parameter PRELOAD, default 4: TX words written before transmission is started (range 1..15).
REQ-003 Parameter STOP_BIT, default 1: bit index of the stop field inside the control word.
REQ-004 pclk  input  1  sole clock; all logic on rising edge.
REQ-005 preset  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a session.
REQ-007 stop_req  input  1  one-cycle request to end a session.
REQ-008 cfg_word  input  32  control word; sampled on an accepted start.
REQ-009 tx_valid / tx_ready  input / output  1 / 1  producer handshake for TX words.
REQ-010 tx_data  input  32  TX word, valid while tx_valid=1.
REQ-011 rx_valid / rx_ready  output / input  1 / 1  consumer handshake for RX words.
REQ-012 rx_data  output  32  RX word; stable while rx_valid=1.
REQ-013 tx_full / rx_empty  input  1 / 1  transceiver TxFIFO full and RxFIFO empty flags.
REQ-014 psel, penable, pwrite  output  1 each  APB master control.
REQ-015 paddr / pwdata  output  32 / 32  APB address and write data.
REQ-016 prdata / pready  input  32 / 1  APB read data and ready.
REQ-017 busy / done  output  1 / 1  session active; one-cycle pulse at session end.
REQ-018 tx_count / rx_count  output  16 / 16  words written and words read this session.

Function
REQ-019 Register map: CTRL=ADR_OFFSET+0x0, TXD=ADR_OFFSET+0x4, RXD=ADR_OFFSET+0x8.
REQ-020 APB transfer: setup cycle psel=1, penable=0; access cycles psel=1, penable=1 until pready=1; paddr, pwrite and pwdata are held constant for the whole transfer.
REQ-021 The next transfer's setup cycle may start in the cycle after completion; minimum transfer length is 2 cycles.
REQ-022 FSM states: IDLE, CFG, PRELOAD, GO, RUN, HALT.
REQ-023 IDLE: start=1 captures cfg_word, clears both counters, sets busy=1 and enters CFG; start in any other state is ignored.
REQ-024 CFG: writes CTRL with cfg_word bit STOP_BIT forced to 1, then enters PRELOAD.
REQ-025 PRELOAD: writes TXD PRELOAD times, issuing each write only when tx_valid=1 and tx_full=0; after the last write, enters GO.
REQ-026 TX word acceptance: tx_ready=1 for exactly the setup cycle of a TXD write; tx_data is captured into pwdata in that cycle.
REQ-027 GO: writes CTRL with bit STOP_BIT=0, then enters RUN.
REQ-028 RUN, TX eligible: tx_valid=1 and tx_full=0.
REQ-029 RUN, RX eligible: rx_empty=0 and rx_valid=0.
REQ-030 RUN arbitration: when both TX and RX are eligible, round-robin (grant the opposite of the last grant); after reset, RX has priority.
REQ-031 RX read completion: prdata is registered to rx_data and rx_valid is set next cycle; rx_valid clears on the cycle rx_valid=1 and rx_ready=1.
REQ-032 stop_req at any busy state is latched; the in-flight transfer completes, then the FSM enters HALT.
REQ-033 A stop latched in CFG or PRELOAD skips GO and RUN.
REQ-034 HALT: writes CTRL with bit STOP_BIT=1; on completion, done=1 for one cycle, busy=0, FSM returns to IDLE.
REQ-035 stop_req in IDLE is ignored.
REQ-036 Counters increment on each completed TXD write / RXD read, saturate at 16'hFFFF, and hold their values after done.
REQ-037 Simultaneous start and stop_req in IDLE: start is accepted and the stop is latched.
REQ-038 A pending rx_valid word is held across HALT and IDLE until consumed; no new RX reads are issued outside RUN.

Reset
REQ-039 preset=1 at a clock edge forces state IDLE; psel, penable, pwrite, tx_ready, rx_valid, busy and done=0; paddr, pwdata, rx_data, tx_count and rx_count=0; the latched stop is cleared and arbitration is reset.
REQ-040 Reset during an APB transfer abandons it; no completion is counted.

Verification
REQ-041 Session with PRELOAD=4 and pready always 1, cfg_word=32'h0000_00F0 -> CTRL write 32'h0000_00F2, 4 TXD writes at 0x4, CTRL write 32'h0000_00F0, each transfer exactly 2 cycles.
REQ-042 pready low for 3 access cycles -> transfer lasts 5 cycles; paddr and pwdata are stable throughout.
REQ-043 RUN with tx_valid=1, tx_full=0, rx_empty=0, rx_ready=1 -> grants alternate RX, TX, RX, TX; tx_count and rx_count advance equally.
REQ-044 tx_full=1 in RUN -> no TXD writes; RXD reads continue; rx_valid held while rx_ready=0 with no further reads.
REQ-045 stop_req during the 2nd preload write -> that write completes, HALT writes CTRL with the stop bit set, done pulses, tx_count=2.
REQ-046 preset asserted mid-access with penable=1 -> next cycle psel=0, busy=0, counters=0; a following start runs a full session normally.
